// File: rtl/div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight; the result is held until writeback accepts it.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [1:0]      DivOp,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] DivRes
);

    localparam int unsigned CW = 6;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPEC,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] res_q;

    logic            is_signed_c;
    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic            special_c;
    logic [XLEN:0]   rem_sh_d;
    logic            sub_ok_d;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] quo_fix_d;
    logic [XLEN-1:0] rem_fix_d;

    // Operand magnitudes and special-case detection at accept.
    always_comb begin
        is_signed_c = ~DivOp[0];
        a_neg_c     = is_signed_c & A[XLEN-1];
        b_neg_c     = is_signed_c & B[XLEN-1];
        a_mag_c     = a_neg_c ? XLEN'(XLEN'(0) - A) : A;
        b_mag_c     = b_neg_c ? XLEN'(XLEN'(0) - B) : B;
        special_c   = (B == '0) || (is_signed_c && (A == INT_MIN) && (B == '1));
    end

    // One restoring step; the shifted partial remainder needs XLEN+1 bits.
    always_comb begin
        rem_sh_d  = {rem_q, quo_q[XLEN-1]};
        sub_ok_d  = (rem_sh_d >= {1'b0, dvs_q});
        rem_d     = sub_ok_d ? XLEN'(rem_sh_d - {1'b0, dvs_q}) : rem_sh_d[XLEN-1:0];
        quo_d     = {quo_q[XLEN-2:0], sub_ok_d};
        quo_fix_d = neg_quo_q ? XLEN'(XLEN'(0) - quo_q) : quo_q;
        rem_fix_d = neg_rem_q ? XLEN'(XLEN'(0) - rem_q) : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else if (flush && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q && !flush) begin
                        op_q       <= DivOp;
                        a_q        <= A;
                        b_q        <= B;
                        dvs_q      <= b_mag_c;
                        quo_q      <= a_mag_c;
                        rem_q      <= '0;
                        neg_quo_q  <= a_neg_c ^ b_neg_c;
                        neg_rem_q  <= a_neg_c;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= special_c ? S_SPEC : S_CALC;
                    end
                end
                S_SPEC: begin
                    // Only divide-by-zero and signed overflow reach here.
                    if (b_q == '0) begin
                        res_q <= op_q[1] ? a_q : '1;
                    end else begin
                        res_q <= op_q[1] ? '0 : INT_MIN;
                    end
                    state_q <= S_DONE;
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    res_q   <= op_q[1] ? rem_fix_d : quo_fix_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after DONE is entered.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign DivRes    = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, backpressure, flush and reset abort.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  DivOp;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] DivRes;

    int n_tot = 0;
    int n_bad = 0;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .DivOp     (DivOp),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .DivRes    (DivRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one op at a negedge; returns after the accept edge (+1).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        DivOp    = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        DivOp    = 2'(op + 2'd1);
    endtask

    // Count edges from accept until out_valid is seen, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, DivRes, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ovl"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        DivOp     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", DivRes, 32'd0);
        chk("rst_ovl", 32'(out_valid), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Normal path: 34-cycle latency.
        run_op("div100_7",   OP_DIV,  32'd100,        32'd7,          32'd14,         34);
        run_op("rem100_7",   OP_REM,  32'd100,        32'd7,          32'd2,          34);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        run_op("div7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34);
        run_op("rem7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34);
        run_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34);
        run_op("remu_max_2", OP_REMU, 32'hFFFF_FFFF,  32'd2,          32'd1,          34);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          34);
        run_op("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  34);

        // Special path: 2-cycle latency.
        run_op("div5_0",     OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2);
        run_op("rem5_0",     OP_REM,  32'd5,          32'd0,          32'd5,          2);
        run_op("divu5_0",    OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  2);
        run_op("remu_m3_0",  OP_REMU, 32'hFFFF_FFFD,  32'd0,          32'hFFFF_FFFD,  2);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2);

        // Backpressure: result and in_ready held while out_ready is low.
        issue(OP_DIVU, 32'd1000, 32'd10);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd34);
        held = 32'd100;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_res", DivRes, held);
            chk("bp_ovl", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rdy_after", 32'(in_ready), 32'd1);

        // flush in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        A        = 32'd8;
        B        = 32'd2;
        DivOp    = OP_DIV;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_rdy", 32'(in_ready), 32'd1);
        watch_no_valid("idle_flush_nov", 40);

        // flush at iteration 10.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("fl_busy", 32'(in_ready), 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_ovl", 32'(out_valid), 32'd0);
        watch_no_valid("fl_nov", 40);

        // rst at iteration 10 of a new op.
        issue(OP_DIVU, 32'd12345, 32'd11);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rs_rdy", 32'(in_ready), 32'd1);
        chk("rs_ovl", 32'(out_valid), 32'd0);
        chk("rs_res", DivRes, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_valid("rs_nov", 40);
        run_op("div9_3", OP_DIV, 32'd9, 32'd3, 32'd3, 34);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
